// File: rtl/tlu_ch_tx_if.sv
// tlu_ch_tx_if: the three-wire EUDET-style trigger link between one TLU
// channel and one DUT port.
//   TLU_TRIGGER  TLU -> DUT  trigger pulse / serial trigger-ID data
//   TLU_BUSY     DUT -> TLU  DUT busy (asynchronous to the TLU clock)
//   TLU_CLOCK    DUT -> TLU  DUT readout clock (asynchronous)
// master = TLU side, slave = DUT side.
interface tlu_ch_tx_if;
  logic TLU_TRIGGER;
  logic TLU_BUSY;
  logic TLU_CLOCK;

  modport master (output TLU_TRIGGER, input TLU_BUSY, input TLU_CLOCK);
  modport slave  (input TLU_TRIGGER, output TLU_BUSY, output TLU_CLOCK);
endinterface

// File: rtl/tlu_ch_tx.sv
// tlu_ch_tx: per-channel TLU trigger transmitter toward one DUT port.
// Issues an accepted trigger as a fixed pulse (MODE 0), a busy handshake
// (MODE 1/3) or a busy handshake followed by a DUT-clocked, LSB-first
// serial trigger-ID readout (MODE 2). Single CLK40 domain; the DUT's
// BUSY and CLOCK lines are synchronised internally.
//
// Ports:
//   CLK40, RST_N      clock, asynchronous active-low reset
//   EN                channel enable (gates new accepts only)
//   MODE              0 pulse, 1 busy handshake, 2 data handshake, 3 = 1
//   PULSE_LEN         mode-0 high time in cycles (0 acts as 1)
//   TIMEOUT           cycle limit per wait phase (0 disables)
//   TRIG_START/TRIG_ID request strobe and ID, taken when READY=1
//   READY             idle and able to accept (combinational)
//   lnk               DUT link (TLU_TRIGGER out, TLU_BUSY/TLU_CLOCK in)
//   TIMEOUT_ERR       one-cycle pulse on a timeout abort
//   TIMEOUT_CNT       saturating count of timeout aborts
//   LAST_ID           last accepted ID
//   ACK_LATENCY       trigger-to-busy latency; only live when the macro
//                     TLU_CH_TX_ACK_LATENCY_EN is defined, else tied to 0
module tlu_ch_tx #(
  parameter int ID_BITS     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK40,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [1:0]         MODE,
  input  logic [7:0]         PULSE_LEN,
  input  logic [15:0]        TIMEOUT,
  input  logic               TRIG_START,
  input  logic [ID_BITS-1:0] TRIG_ID,
  output logic               READY,
  tlu_ch_tx_if.master        lnk,
  output logic               TIMEOUT_ERR,
  output logic [7:0]         TIMEOUT_CNT,
  output logic [ID_BITS-1:0] LAST_ID,
  output logic [15:0]        ACK_LATENCY
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int BW = $clog2(ID_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, PULSE, WAIT_ACK, SHIFT, WAIT_RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic               trig, trig_nxt;
  logic [SS-1:0]      busy_sync, clk_sync;
  logic               busy_s, clk_s, clk_s_d, clk_rise;
  logic               data_mode;
  logic [ID_BITS-1:0] id_sr;
  logic [BW-1:0]      bit_cnt;
  logic [7:0]         pcnt, plen;
  logic [15:0]        to_cnt;
  logic               accept, to_hit, to_fire, shift_en, waiting;

  // ---------------- DUT input synchronisers ----------------
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      busy_sync <= '0;
      clk_sync  <= '0;
      clk_s_d   <= 1'b0;
    end else begin
      busy_sync <= {busy_sync[SS-2:0], lnk.TLU_BUSY};
      clk_sync  <= {clk_sync[SS-2:0], lnk.TLU_CLOCK};
      clk_s_d   <= clk_s;
    end
  end

  assign busy_s   = busy_sync[SS-1];
  assign clk_s    = clk_sync[SS-1];
  assign clk_rise = clk_s & ~clk_s_d;

  assign READY  = (state == IDLE) & EN & ((MODE == 2'd0) | ~busy_s);
  assign accept = TRIG_START & READY;

  assign waiting = (state == WAIT_ACK) | (state == SHIFT) | (state == WAIT_RELEASE);
  // Fires in the cycle the phase has lasted TIMEOUT cycles; the abort is
  // visible on the following edge.
  assign to_hit  = (TIMEOUT != 16'd0) && ({1'b0, to_cnt} + 17'd1 >= {1'b0, TIMEOUT});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      trig  <= 1'b0;
    end else begin
      state <= state_nxt;
      trig  <= trig_nxt;
    end
  end

  // ---------------- FSM: next state / line value ----------------
  // A busy change (progress) always beats a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    trig_nxt  = trig;
    to_fire   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        trig_nxt = 1'b0;
        if (accept) begin
          trig_nxt  = 1'b1;
          state_nxt = (MODE == 2'd0) ? PULSE : WAIT_ACK;
        end
      end
      PULSE: begin
        if (pcnt >= plen) begin
          trig_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      WAIT_ACK: begin
        if (busy_s) begin
          trig_nxt  = 1'b0;
          state_nxt = data_mode ? SHIFT : WAIT_RELEASE;
        end else if (to_hit) begin
          trig_nxt  = 1'b0;
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (!busy_s) begin
          // DUT gave up early: clean return, not an error
          trig_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (to_hit) begin
          trig_nxt  = 1'b0;
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end else if (clk_rise) begin
          if (bit_cnt == BW'(ID_BITS)) begin
            // one clock beyond the ID: park the line low
            trig_nxt  = 1'b0;
            state_nxt = WAIT_RELEASE;
          end else begin
            trig_nxt = id_sr[0];
            shift_en = 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        trig_nxt = 1'b0;
        if (!busy_s) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        trig_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign lnk.TLU_TRIGGER = trig;

  // ---------------- datapath ----------------
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      data_mode   <= 1'b0;
      id_sr       <= '0;
      bit_cnt     <= '0;
      pcnt        <= 8'd0;
      plen        <= 8'd0;
      to_cnt      <= 16'd0;
      TIMEOUT_ERR <= 1'b0;
      TIMEOUT_CNT <= 8'd0;
      LAST_ID     <= '0;
    end else begin
      TIMEOUT_ERR <= to_fire;
      if (to_fire && TIMEOUT_CNT != 8'hFF)
        TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;

      if (accept) begin
        data_mode <= (MODE == 2'd2);
        id_sr     <= TRIG_ID;
        LAST_ID   <= TRIG_ID;
        bit_cnt   <= '0;
        pcnt      <= 8'd1;
        plen      <= (PULSE_LEN == 8'd0) ? 8'd1 : PULSE_LEN;
      end else begin
        if (state == PULSE)
          pcnt <= pcnt + 8'd1;
        if (shift_en) begin
          id_sr   <= id_sr >> 1;
          bit_cnt <= bit_cnt + BW'(1);
        end
      end

      // per-phase timeout counter restarts on every state change
      if (state_nxt != state)
        to_cnt <= 16'd0;
      else if (waiting && to_cnt != 16'hFFFF)
        to_cnt <= to_cnt + 16'd1;
    end
  end

`ifdef TLU_CH_TX_ACK_LATENCY_EN
  // ACK_LATENCY = number of cycles TLU_TRIGGER was high before BUSY_S was
  // seen, synchroniser delay included; 0xFFFF marks a timeout.
  logic [15:0] lat_cnt, ack_lat;

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      lat_cnt <= 16'd0;
      ack_lat <= 16'd0;
    end else begin
      if (accept && MODE != 2'd0)
        lat_cnt <= 16'd0;
      else if (state == WAIT_ACK && lat_cnt != 16'hFFFF)
        lat_cnt <= lat_cnt + 16'd1;

      if (to_fire)
        ack_lat <= 16'hFFFF;
      else if (state == WAIT_ACK && busy_s)
        ack_lat <= (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;
    end
  end

  assign ACK_LATENCY = ack_lat;
`else
  assign ACK_LATENCY = 16'd0;
`endif

endmodule

// File: tb/tb_tlu_ch_tx.sv
// tb_tlu_ch_tx: directed bench for tlu_ch_tx. Expected waveforms of
// TLU_TRIGGER / READY / TIMEOUT_ERR are derived per transaction from the
// stimulus timing (accept cycle, DUT busy/clock edges, sync depth) and
// compared every cycle; literal checks pin reset values, shifted bits,
// counters and the asynchronous reset.
module tb_tlu_ch_tx;
  localparam int IDB = 15;
  localparam int S   = 2;
  localparam int N   = 4096;

  logic            CLK40 = 1'b0;
  logic            RST_N, EN, TRIG_START, READY, TIMEOUT_ERR;
  logic [1:0]      MODE;
  logic [7:0]      PULSE_LEN, TIMEOUT_CNT;
  logic [15:0]     TIMEOUT, ACK_LATENCY;
  logic [IDB-1:0]  TRIG_ID, LAST_ID;

  tlu_ch_tx_if lnk ();

  tlu_ch_tx #(.ID_BITS(IDB), .SYNC_STAGES(S)) u_dut (
    .CLK40(CLK40), .RST_N(RST_N), .EN(EN), .MODE(MODE),
    .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT), .TRIG_START(TRIG_START),
    .TRIG_ID(TRIG_ID), .READY(READY), .lnk(lnk),
    .TIMEOUT_ERR(TIMEOUT_ERR), .TIMEOUT_CNT(TIMEOUT_CNT),
    .LAST_ID(LAST_ID), .ACK_LATENCY(ACK_LATENCY)
  );

  always #12 CLK40 = ~CLK40;

  int cyc = 0;
  int npass = 0, ntot = 0;
  int lim = N;
  int rr[16];

  // expected waveforms: [0]=TLU_TRIGGER [1]=READY [2]=TIMEOUT_ERR
  bit   en_a[3][N];
  logic ex_a[3][N];
  string nm[3] = '{"trig", "ready", "err"};

  initial forever begin
    @(posedge CLK40);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  initial forever begin
    @(negedge CLK40);
    if (RST_N && cyc < N) begin
      logic [2:0] act;
      act = {TIMEOUT_ERR, READY, lnk.TLU_TRIGGER};
      for (int s = 0; s < 3; s++)
        if (en_a[s][cyc]) chk(nm[s], act[s], ex_a[s][cyc]);
    end
  end

  task automatic ex(input int s, input int c, input logic v);
    if (c >= 0 && c < N && c <= lim) begin
      en_a[s][c] = 1'b1;
      ex_a[s][c] = v;
    end
  endtask

  task automatic ex_rng(input int s, input int c0, input int c1, input logic v);
    for (int c = c0; c <= c1; c++) ex(s, c, v);
  endtask

  // Mode 0, accept in cycle a: line high for max(L,1) cycles from a+1.
  task automatic m_pulse(input int a, input int L);
    int le;
    le = (L == 0) ? 1 : L;
    ex(0, a, 1'b0); ex(1, a, 1'b1);
    ex_rng(0, a + 1, a + le, 1'b1);
    ex_rng(1, a + 1, a + le, 1'b0);
    ex(0, a + le + 1, 1'b0); ex(1, a + le + 1, 1'b1);
    ex_rng(2, a + 1, a + le + 1, 1'b0);
  endtask

  // Busy handshake, accept in cycle a, DUT busy raised in cycle b and
  // dropped in cycle f (b<0: never, so a timeout of T cycles applies).
  task automatic m_hs(input int a, input int b, input int f, input int T, input logic rdy_end);
    ex(0, a, 1'b0); ex(1, a, 1'b1);
    if (b < 0) begin
      ex_rng(0, a + 1, a + T, 1'b1);
      ex_rng(1, a + 1, a + T, 1'b0);
      ex_rng(2, a + 1, a + T, 1'b0);
      ex(0, a + T + 1, 1'b0); ex(2, a + T + 1, 1'b1); ex(1, a + T + 1, rdy_end);
    end else begin
      ex_rng(0, a + 1, b + S, 1'b1);
      ex_rng(0, b + S + 1, f + S + 1, 1'b0);
      ex_rng(1, a + 1, f + S, 1'b0);
      ex(1, f + S + 1, rdy_end);
      ex_rng(2, a + 1, f + S + 1, 1'b0);
    end
  endtask

  // Data handshake with nr DUT clock rises at rr[]; bit i is on the line
  // from the rise after rr[i] has been synchronised until the next one.
  task automatic m_data(input int a, input int b, input int f, input int nr, input logic [IDB-1:0] id);
    int e;
    logic v;
    ex(0, a, 1'b0); ex(1, a, 1'b1);
    ex_rng(0, a + 1, b + S, 1'b1);
    ex_rng(0, b + S + 1, rr[0] + S, 1'b0);
    for (int i = 0; i < nr; i++) begin
      v = (i < IDB) ? id[i] : 1'b0;
      e = (i + 1 < nr) ? rr[i + 1] + S : f + S + 1;
      ex_rng(0, rr[i] + S + 1, e, v);
    end
    ex_rng(1, a + 1, f + S, 1'b0);
    ex(1, f + S + 1, 1'b1);
    ex_rng(2, a + 1, f + S + 1, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK40);
      #1;
    end
  endtask

  task automatic count_hi(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge CLK40);
      if (lnk.TLU_TRIGGER) hi++;
      tick(1);
    end
  endtask

  // Accept + n DUT clocks of period 8 (high 4); bit i sampled just before
  // the next DUT clock rise, as the DUT would see it.
  task automatic dut_clocks(input int n, output logic [IDB-1:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      lnk.TLU_CLOCK = 1'b1; tick(4);
      lnk.TLU_CLOCK = 1'b0; tick(3);
      @(negedge CLK40);
      if (i < IDB) bits[i] = lnk.TLU_TRIGGER;
      if (i + 1 < n) tick(1);
    end
  endtask

  initial begin
    int a, b, f, hi, nerr;
    logic [IDB-1:0] bits;
    RST_N = 1'b0; EN = 1'b0; MODE = 2'd0; PULSE_LEN = 8'd0; TIMEOUT = 16'd0;
    TRIG_START = 1'b0; TRIG_ID = '0;
    lnk.TLU_BUSY = 1'b0; lnk.TLU_CLOCK = 1'b0;
    tick(3);
    chk("rst_trig", lnk.TLU_TRIGGER, 0);
    chk("rst_ready", READY, 0);
    chk("rst_err", TIMEOUT_ERR, 0);
    chk("rst_tocnt", TIMEOUT_CNT, 0);
    chk("rst_lastid", LAST_ID, 0);
    chk("rst_acklat", ACK_LATENCY, 0);
    RST_N = 1'b1; EN = 1'b1;
    tick(3);

    // mode 0, PULSE_LEN = 3 and 0
    MODE = 2'd0; PULSE_LEN = 8'd3;
    a = cyc; m_pulse(a, 3);
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0;
    count_hi(6, hi);
    chk("pulse3_len", hi, 3);
    PULSE_LEN = 8'd0;
    a = cyc; m_pulse(a, 0);
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0;
    count_hi(4, hi);
    chk("pulse0_len", hi, 1);

    // mode 2, ID 0x2A5B, 16 DUT clocks
    MODE = 2'd2; TIMEOUT = 16'd0; TRIG_ID = 15'h2A5B;
    a = cyc; b = a + 6;
    for (int i = 0; i < 16; i++) rr[i] = b + 10 + 8 * i;
    f = rr[15] + 8;
    m_data(a, b, f, 16, 15'h2A5B);
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0; TRIG_ID = '0;
    tick(b - cyc); lnk.TLU_BUSY = 1'b1;
    tick(rr[0] - cyc);
    dut_clocks(16, bits);
    tick(1);
    lnk.TLU_BUSY = 1'b0;
    tick(S + 3);
    chk("id_bits", bits, 15'h2A5B);
    chk("last_id", LAST_ID, 15'h2A5B);

    // mode 1, busy never rises, timeout 100
    MODE = 2'd1; TIMEOUT = 16'd100;
    a = cyc; m_hs(a, -1, 0, 100, 1'b1);
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0;
    tick(105);
    chk("tocnt_1", TIMEOUT_CNT, 1);
`ifdef TLU_CH_TX_ACK_LATENCY_EN
    chk("acklat_to", ACK_LATENCY, 16'hFFFF);
`else
    chk("acklat_off", ACK_LATENCY, 0);
`endif

    // mode 3 (= busy handshake), EN dropped right after accept
    MODE = 2'd3; TIMEOUT = 16'd50;
    a = cyc; b = a + 4; f = b + 10;
    m_hs(a, b, f, 50, 1'b0);
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0; EN = 1'b0;
    tick(b - cyc); lnk.TLU_BUSY = 1'b1;
    tick(f - cyc); lnk.TLU_BUSY = 1'b0;
    tick(S + 3);
    chk("tocnt_hs", TIMEOUT_CNT, 1);
`ifdef TLU_CH_TX_ACK_LATENCY_EN
    chk("acklat_hs", ACK_LATENCY, 6);
`endif
    EN = 1'b1; tick(1);
    chk("ready_en", READY, 1);

    // mode 1, busy already high: request ignored, not queued
    MODE = 2'd1; lnk.TLU_BUSY = 1'b1;
    tick(S + 2);
    a = cyc;
    ex_rng(1, a, a + 3, 1'b0);
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0;
    tick(2);
    f = cyc;
    ex_rng(0, a, f + S + 3, 1'b0);
    ex(1, f + S - 1, 1'b0);
    ex_rng(1, f + S, f + S + 3, 1'b1);
    lnk.TLU_BUSY = 1'b0;
    tick(S + 5);

    // mode 2, asynchronous reset after 7 shifted bits
    MODE = 2'd2; TIMEOUT = 16'd0; TRIG_ID = 15'h1255;
    a = cyc; b = a + 6;
    for (int i = 0; i < 16; i++) rr[i] = b + 10 + 8 * i;
    lim = rr[6] + 6;
    m_data(a, b, rr[6] + 8, 7, 15'h1255);
    lim = N;
    TRIG_START = 1'b1; tick(1); TRIG_START = 1'b0;
    tick(b - cyc); lnk.TLU_BUSY = 1'b1;
    tick(rr[0] - cyc);
    dut_clocks(7, bits);
    chk("pre_rst_bits", bits[6:0], 7'h55);
    chk("pre_rst_trig", lnk.TLU_TRIGGER, 1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_trig", lnk.TLU_TRIGGER, 0);
    lnk.TLU_BUSY = 1'b0; lnk.TLU_CLOCK = 1'b0;
    tick(2);
    RST_N = 1'b1;
    chk("rst_lastid2", LAST_ID, 0);
    tick(S + 1);
    chk("ready_after_rst", READY, 1);

    // 260 back-to-back timeouts with TIMEOUT = 1
    MODE = 2'd1; TIMEOUT = 16'd1;
    a = cyc;
    for (int k = 0; k < 260; k++) m_hs(a + 2 * k, -1, 0, 1, 1'b1);
    nerr = 0;
    TRIG_START = 1'b1;
    for (int k = 0; k < 522; k++) begin
      if (k == 519) TRIG_START = 1'b0;
      @(negedge CLK40);
      if (TIMEOUT_ERR) nerr++;
      tick(1);
    end
    chk("nerr_260", nerr, 260);
    chk("tocnt_sat", TIMEOUT_CNT, 255);
    chk("idle_trig", lnk.TLU_TRIGGER, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/tlu_ch_tx.md
Name: tlu_ch_tx

Overview:
- Per-channel TLU trigger transmitter toward one DUT port: drives TLU_TRIGGER and consumes DUT BUSY/CLOCK.
- Counterpart of the per-channel input receiver: the receiver time-stamps incoming pulses; this block issues the accepted trigger to a DUT using the EUDET-style handshake.
- Supports three modes: fixed pulse, busy handshake, and handshake with serial trigger-ID readout clocked by the DUT.
- Sits in tlu_master, one instance per DUT output. Single CLK40 domain; DUT inputs are synchronised internally.

Parameters:
- ID_BITS, 15, width of trigger ID shifted to DUT.
- SYNC_STAGES, 2, flip-flop depth of the BUSY/CLOCK synchronisers (minimum 2).

Ports:
- CLK40  in  1  system clock, only clock.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  channel enable; gates acceptance only.
- MODE  in  2  0=pulse, 1=busy handshake, 2=data handshake, 3=treated as 1.
- PULSE_LEN  in  8  mode-0 high time in cycles; 0 treated as 1.
- TIMEOUT  in  16  cycle limit per wait phase; 0 disables.
- TRIG_START  in  1  request strobe; honoured only when READY=1.
- TRIG_ID  in  ID_BITS  ID captured with TRIG_START.
- READY  out  1  block idle and able to accept.
- TLU_TRIGGER  out  1  registered trigger/data line to DUT.
- TLU_BUSY  in  1  DUT busy, asynchronous.
- TLU_CLOCK  in  1  DUT readout clock, asynchronous.
- TIMEOUT_ERR  out  1  one-cycle pulse on timeout abort.
- TIMEOUT_CNT  out  8  saturating timeout count.
- LAST_ID  out  ID_BITS  last accepted ID.
- ACK_LATENCY  out  16  see Optional Feature.

Behaviour:
- Reset: async on RST_N low. State=IDLE; TLU_TRIGGER, TIMEOUT_ERR, TIMEOUT_CNT, LAST_ID, ACK_LATENCY, shift register, counters and synchroniser flops all 0.
- BUSY_S and CLK_S are the SYNC_STAGES-synchronised inputs. CLK_RISE = CLK_S & ~CLK_S_d (one extra flop).
- READY = (state==IDLE) & EN & (MODE==0 | ~BUSY_S). Combinational.
- Accept when TRIG_START & READY. MODE is sampled at accept; ID and LAST_ID are captured at accept. TLU_TRIGGER rises on the next edge (latency 1 cycle).
- States:
  - IDLE --accept--> PULSE (mode 0) or WAIT_ACK (modes 1, 2, 3).
  - PULSE: TLU_TRIGGER high exactly max(PULSE_LEN,1) cycles, then IDLE.
  - WAIT_ACK: TLU_TRIGGER high until BUSY_S=1, then TLU_TRIGGER<=0.
    - Mode 1 -> WAIT_RELEASE.
    - Mode 2 -> SHIFT.
  - SHIFT: on each CLK_RISE, TLU_TRIGGER<=ID[bit], LSB first, bit index 0..ID_BITS-1.
    - After ID_BITS edges, TLU_TRIGGER<=0 and go to WAIT_RELEASE.
    - If BUSY_S falls early: TLU_TRIGGER<=0, go to IDLE, no error.
  - WAIT_RELEASE: extra CLK_RISE ignored (line held 0); BUSY_S=0 -> IDLE.
- Timeout:
  - Counter clears on every state entry and counts in WAIT_ACK, SHIFT and WAIT_RELEASE.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): TLU_TRIGGER<=0, TIMEOUT_ERR=1 for one cycle, TIMEOUT_CNT+1 (saturates at 255), state=IDLE.
- EN deassert mid-transaction: the transaction completes normally; only new accepts are blocked.
- TRIG_START while READY=0: ignored; not queued, no error.
- Simultaneous BUSY_S fall and timeout in the same cycle: normal completion wins, no error.

Optional Feature:
- Macro TLU_CH_TX_ACK_LATENCY_EN.
- Defined:
  - A 16-bit counter starts at TLU_TRIGGER rise in WAIT_ACK and saturates at 0xFFFF.
  - On the BUSY_S rise, ACK_LATENCY <= cycles since TLU_TRIGGER rise (includes synchroniser delay).
  - On timeout, ACK_LATENCY <= 0xFFFF.
- Undefined: ACK_LATENCY is tied to 0 and no counter logic is present.

Test Plan:
- Mode 0, PULSE_LEN=3, TRIG_START at cycle 10 -> TLU_TRIGGER high cycles 11-13, READY=1 from cycle 14; PULSE_LEN=0 -> exactly 1 cycle high.
- Mode 2, TRIG_ID=15'h2A5B: DUT raises BUSY 5 cycles after trigger, then applies 15 clocks of period 8 -> TLU_TRIGGER falls after BUSY sync; sampled bits LSB first = 1,1,0,1,1,0,1,0,0,1,0,1,0,1,0. 16th clock drives 0; BUSY low -> READY=1; LAST_ID=0x2A5B.
- Mode 1, TIMEOUT=100, BUSY never rises -> TLU_TRIGGER drops and TIMEOUT_ERR pulses 100 cycles after entering WAIT_ACK. TIMEOUT_CNT=1. With macro, ACK_LATENCY=0xFFFF.
- Mode 1, BUSY already high, TRIG_START pulsed -> READY=0, no TLU_TRIGGER activity. After BUSY low plus sync delay, READY=1.
- Mode 2: RST_N low after 7 shifted bits -> TLU_TRIGGER=0 immediately (async). After release, state IDLE and READY=1 once BUSY low.
- TIMEOUT_CNT saturation: 260 consecutive timeouts -> TIMEOUT_CNT=255.
